vram_slot_arbiter: RTL and testbench

- Time-slot arbiter sharing one synchronous single-port video RAM between two requesters: the display fetch path and the 8-bit host CPU port.
- Runs on the 48 MHz internal-oscillator clock.
- A free-running slot counter (default divide-by-8, giving a 6 MHz slot rate) reserves one RAM cycle per slot for display fetch. All other cycles serve host reads and writes through a req/ack handshake.

---
 rtl/vram_slot_arbiter.sv | 142 ++++++++++++++
 tb/tb_vram_slot_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter for a single-port video RAM: one reserved display fetch per slot,
// all remaining cycles serve the host CPU through a req/ack handshake.
module vram_slot_arbiter #(
  parameter int SLOTS = 8,
  parameter int AW    = 15,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          disp_en,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  output logic [7:0]    slot_cnt,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_ISSUE = 2'd1,
    H_CAPT  = 2'd2,
    H_ACK   = 2'd3
  } host_state_t;

  localparam logic [7:0] LAST_SLOT = 8'(SLOTS - 1);

  logic [7:0]    slot_cnt_r;
  logic          disp_next_s;
  logic          disp_cyc_r;
  logic          disp_capt_r;
  logic          disp_valid_r;
  logic [DW-1:0] disp_data_r;
  host_state_t   host_state_r;
  logic          op_we_r;
  logic          host_ack_r;
  logic [DW-1:0] host_rdata_r;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_wdata_r;
  logic          ram_we_r;

  // Flags that the coming cycle is reserved for a display fetch
  always_comb begin
    if (disp_en && (slot_cnt_r == LAST_SLOT)) begin
      disp_next_s = 1'b1;
    end else begin
      disp_next_s = 1'b0;
    end
  end

  // Free-running slot phase counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slot_cnt_r <= 8'd0;
    end else if (slot_cnt_r == LAST_SLOT) begin
      slot_cnt_r <= 8'd0;
    end else begin
      slot_cnt_r <= slot_cnt_r + 8'd1;
    end
  end

  // Display pipeline: address cycle, capture cycle, then a one-cycle valid pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      disp_cyc_r   <= 1'b0;
      disp_capt_r  <= 1'b0;
      disp_valid_r <= 1'b0;
      disp_data_r  <= {DW{1'b0}};
    end else begin
      disp_cyc_r   <= disp_next_s;
      disp_capt_r  <= disp_cyc_r;
      disp_valid_r <= disp_capt_r;
      if (disp_capt_r) begin
        disp_data_r <= ram_rdata;
      end
    end
  end

  // Host FSM and RAM port ownership; a display cycle always takes the port
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      host_state_r <= H_IDLE;
      op_we_r      <= 1'b0;
      host_ack_r   <= 1'b0;
      host_rdata_r <= {DW{1'b0}};
      ram_addr_r   <= {AW{1'b0}};
      ram_wdata_r  <= {DW{1'b0}};
      ram_we_r     <= 1'b0;
    end else begin
      ram_we_r   <= 1'b0;
      host_ack_r <= 1'b0;
      if (disp_next_s) begin
        ram_addr_r <= disp_addr;
      end
      case (host_state_r)
        H_IDLE: begin
          if (host_req && !disp_next_s) begin
            ram_addr_r   <= host_addr;
            ram_wdata_r  <= host_wdata;
            ram_we_r     <= host_we;
            op_we_r      <= host_we;
            host_state_r <= H_ISSUE;
          end
        end
        H_ISSUE: begin
          host_state_r <= H_CAPT;
        end
        H_CAPT: begin
          if (!op_we_r) begin
            host_rdata_r <= ram_rdata;
          end
          host_ack_r   <= 1'b1;
          host_state_r <= H_ACK;
        end
        H_ACK: begin
          host_state_r <= H_IDLE;
        end
        default: begin
          host_state_r <= H_IDLE;
        end
      endcase
    end
  end

  assign slot_cnt   = slot_cnt_r;
  assign disp_data  = disp_data_r;
  assign disp_valid = disp_valid_r;
  assign host_ack   = host_ack_r;
  assign host_rdata = host_rdata_r;
  assign ram_addr   = ram_addr_r;
  assign ram_wdata  = ram_wdata_r;
  assign ram_we     = ram_we_r;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Randomized bench for vram_slot_arbiter: cycle-indexed expectation tables built from
// slot timing and host latency rules, plus a RAM model attached to the DUT port.
module tb_vram_slot_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int SLOTS = 8;
  localparam int NCYC  = 2048;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          disp_en;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic [7:0]    slot_cnt;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_slot_arbiter #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .nrst(nrst),
    .disp_en(disp_en), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .slot_cnt(slot_cnt),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM attached to the DUT
  logic [7:0] ram_mem [0:32767];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
  end

  // Reference state: memory contents and per-cycle expectations
  logic [7:0]  model_mem [0:32767];
  bit          exp_ack  [NCYC];
  bit          exp_isrd [NCYC];
  bit          exp_dv   [NCYC];
  bit          exp_we   [NCYC];
  bit          exp_av   [NCYC];
  bit          exp_wv   [NCYC];
  logic [7:0]  exp_rd   [NCYC];
  logic [7:0]  exp_dd   [NCYC];
  logic [7:0]  exp_wd   [NCYC];
  logic [14:0] exp_addr [NCYC];
  int          cyc;
  int          host_free;
  int          last_dec;
  logic [7:0]  model_rdata;
  bit          ack_prev;
  bit          found;
  int          mode;
  int          n_checks = 0;
  int          n_fails = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCYC; i++) begin
      exp_ack[i] = 1'b0; exp_isrd[i] = 1'b0; exp_dv[i] = 1'b0; exp_we[i] = 1'b0;
      exp_av[i] = 1'b0;  exp_wv[i] = 1'b0;
      exp_rd[i] = 8'h00; exp_dd[i] = 8'h00; exp_wd[i] = 8'h00; exp_addr[i] = 15'h0;
    end
    cyc = 0;
    host_free = 0;
    last_dec = -100;
    model_rdata = 8'h00;
    ack_prev = 1'b0;
  endtask

  task automatic check_reset_vals();
    check_val("rst_slot_cnt",   32'(slot_cnt),   32'd0);
    check_val("rst_disp_data",  32'(disp_data),  32'd0);
    check_val("rst_disp_valid", 32'(disp_valid), 32'd0);
    check_val("rst_host_ack",   32'(host_ack),   32'd0);
    check_val("rst_host_rdata", 32'(host_rdata), 32'd0);
    check_val("rst_ram_addr",   32'(ram_addr),   32'd0);
    check_val("rst_ram_wdata",  32'(ram_wdata),  32'd0);
    check_val("rst_ram_we",     32'(ram_we),     32'd0);
  endtask

  task automatic check_cycle();
    check_val("slot_cnt", 32'(slot_cnt), 32'(cyc % SLOTS));
    if (exp_ack[cyc] && exp_isrd[cyc]) model_rdata = exp_rd[cyc];
    check_val("host_ack", 32'(host_ack), 32'(exp_ack[cyc]));
    if (exp_ack[cyc]) check_val("host_rdata", 32'(host_rdata), 32'(model_rdata));
    check_val("disp_valid", 32'(disp_valid), 32'(exp_dv[cyc]));
    if (exp_dv[cyc]) check_val("disp_data", 32'(disp_data), 32'(exp_dd[cyc]));
    check_val("ram_we", 32'(ram_we), 32'(exp_we[cyc]));
    if (exp_av[cyc]) check_val("ram_addr", 32'(ram_addr), 32'(exp_addr[cyc]));
    if (exp_wv[cyc]) check_val("ram_wdata", 32'(ram_wdata), 32'(exp_wd[cyc]));
  endtask

  // Decide what the cycle's inputs cause: display fetches win, host waits
  task automatic model_eval();
    int slot;
    bit dnext;
    slot  = cyc % SLOTS;
    dnext = disp_en && (slot == SLOTS - 1);
    if (dnext) begin
      exp_av[cyc+1]   = 1'b1;
      exp_addr[cyc+1] = disp_addr;
      exp_dv[cyc+3]   = 1'b1;
      exp_dd[cyc+3]   = model_mem[disp_addr];
    end
    if (host_req && cyc >= host_free && !dnext) begin
      last_dec        = cyc;
      host_free       = cyc + 4;
      exp_av[cyc+1]   = 1'b1;
      exp_addr[cyc+1] = host_addr;
      exp_ack[cyc+3]  = 1'b1;
      if (host_we) begin
        exp_we[cyc+1] = 1'b1;
        exp_wv[cyc+1] = 1'b1;
        exp_wd[cyc+1] = host_wdata;
        model_mem[host_addr] = host_wdata;
        exp_isrd[cyc+3] = 1'b0;
      end else begin
        exp_isrd[cyc+3] = 1'b1;
        exp_rd[cyc+3]   = model_mem[host_addr];
      end
    end
  endtask

  task automatic drive_inputs();
    case (mode)
      0: if ($urandom_range(0, 5) == 0) disp_en = ~disp_en;
      2: disp_en = ($urandom_range(0, 15) != 0);
      default: disp_en = 1'b0;
    endcase
    disp_addr = ($urandom_range(0, 3) == 0) ? 15'h0123 : 15'($urandom_range(0, 15));
    if (!host_req || ack_prev) begin
      if (mode == 1) host_req = 1'b1;
      else if (mode == 3) host_req = 1'b0;
      else host_req = ($urandom_range(0, 3) != 0);
      host_we    = 1'($urandom_range(0, 1));
      host_addr  = 15'($urandom_range(0, 15));
      host_wdata = 8'($urandom);
    end
    ack_prev = exp_ack[cyc];
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic release_reset();
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check_cycle();
    drive_inputs();
    model_eval();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram_mem[i]   = 8'(i) ^ 8'h3C;
      model_mem[i] = 8'(i) ^ 8'h3C;
    end
    ram_mem[15'h0123]   = 8'h5A;
    model_mem[15'h0123] = 8'h5A;
    disp_en = 1'b0; disp_addr = 15'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 15'h0; host_wdata = 8'h00;
    mode = 3;
    clear_model();
    repeat (2) @(negedge clk);
    check_reset_vals();
    release_reset();

    for (int seg = 0; seg < 4; seg++) begin
      mode = (seg == 0) ? 3 : seg - 1;
      for (int k = 0; k < ((mode == 3) ? 40 : 300); k++) begin
        next_cycle();
        drive_inputs();
        model_eval();
      end
      // Hunt for a host access in its capture cycle, then reset mid-access
      found = 1'b0;
      for (int k = 0; k < 64 && !found; k++) begin
        next_cycle();
        if (cyc == last_dec + 2) found = 1'b1;
        else begin
          drive_inputs();
          model_eval();
        end
      end
      #2;
      nrst = 1'b0;
      #1;
      check_reset_vals();
      clear_model();
      @(negedge clk);
      release_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
